// File: rtl/spi_cmd_decoder_pkg.sv
// Shared opcode/state encodings and CSR address map for spi_cmd_decoder.
// Used by the default build and by the SPI_CMD_DECODER_ERR_CNT_EN build.
package spi_cmd_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_CSR   = 4'h1,
        OP_START = 4'h3,
        OP_VEC   = 4'h4,
        OP_MAT   = 4'h5,
        OP_READ  = 4'h6
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CSR_DATA = 2'd1,
        ST_LOAD_VEC = 2'd2,
        ST_LOAD_MAT = 2'd3
    } state_e;

    localparam logic [11:0] CSR_VEC_LEN  = 12'h001;
    localparam logic [11:0] CSR_MAT_COLS = 12'h002;
    localparam logic [11:0] CSR_ERR_CLR  = 12'hFFF;
    localparam logic [11:0] CSR_ERR_CNT  = 12'hFFE;
    localparam logic [7:0]  ERR_CNT_MAX  = 8'hFF;

    function automatic op_e word_opcode(input logic [15:0] word);
        return op_e'(word[15:12]);
    endfunction

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Host-word input and CSR/memory/control output bundle of spi_cmd_decoder.
// err_cnt exists only when SPI_CMD_DECODER_ERR_CNT_EN is defined.
interface spi_cmd_decoder_if #(
    parameter int unsigned ADDR_W = 10
);
    logic [15:0]       in_data;
    logic              in_valid;
    logic              acc_busy;
    logic              csr_wr_en;
    logic [11:0]       csr_wr_addr;
    logic [15:0]       csr_wr_data;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [15:0]       mem_wr_data;
    logic              start;
    logic              rd_req;
    logic              busy;
    logic              err;
`ifdef SPI_CMD_DECODER_ERR_CNT_EN
    logic [7:0]        err_cnt;
`endif

    modport master (
        output in_data, in_valid, acc_busy,
`ifdef SPI_CMD_DECODER_ERR_CNT_EN
        input  err_cnt,
`endif
        input  csr_wr_en, csr_wr_addr, csr_wr_data,
        input  mem_wr_en, mem_wr_addr, mem_wr_data,
        input  start, rd_req, busy, err
    );

    modport slave (
        input  in_data, in_valid, acc_busy,
`ifdef SPI_CMD_DECODER_ERR_CNT_EN
        output err_cnt,
`endif
        output csr_wr_en, csr_wr_addr, csr_wr_data,
        output mem_wr_en, mem_wr_addr, mem_wr_data,
        output start, rd_req, busy, err
    );
endinterface

// File: rtl/spi_cmd_decoder_burst_writer.sv
// Address/word counter for vector and matrix loads; emits registered mem_wr_* strobes.
module cmd_burst_writer #(
    parameter int unsigned       ADDR_W   = 10,
    parameter int unsigned       CNT_W    = 16,
    parameter logic [ADDR_W-1:0] VEC_BASE = 10'h000,
    parameter logic [ADDR_W-1:0] MAT_BASE = 10'h100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_vec,
    input  logic              load_mat,
    input  logic [CNT_W-1:0]  vec_words,
    input  logic [CNT_W-1:0]  mat_words,
    input  logic              word_wr,
    input  logic [15:0]       word_data,
    output logic              last,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [15:0]       mem_wr_data
);
    logic [ADDR_W-1:0] addr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              mem_wr_en_r;
    logic [ADDR_W-1:0] mem_wr_addr_r;
    logic [15:0]       mem_wr_data_r;

    assign last        = (cnt_r == CNT_W'(1));
    assign mem_wr_en   = mem_wr_en_r;
    assign mem_wr_addr = mem_wr_addr_r;
    assign mem_wr_data = mem_wr_data_r;

    // Burst pointer: reloaded at burst start, advanced per data word (wraps naturally).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r <= '0;
            cnt_r  <= '0;
        end else if (load_vec) begin
            addr_r <= VEC_BASE;
            cnt_r  <= vec_words;
        end else if (load_mat) begin
            addr_r <= MAT_BASE;
            cnt_r  <= mat_words;
        end else if (word_wr) begin
            addr_r <= addr_r + ADDR_W'(1);
            cnt_r  <= cnt_r - CNT_W'(1);
        end else begin
            addr_r <= addr_r;
            cnt_r  <= cnt_r;
        end
    end

    // Registered memory write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr_en_r   <= 1'b0;
            mem_wr_addr_r <= '0;
            mem_wr_data_r <= 16'h0000;
        end else begin
            mem_wr_en_r <= word_wr;
            if (word_wr) begin
                mem_wr_addr_r <= addr_r;
                mem_wr_data_r <= word_data;
            end else begin
                mem_wr_addr_r <= mem_wr_addr_r;
                mem_wr_data_r <= mem_wr_data_r;
            end
        end
    end
endmodule

// File: rtl/spi_cmd_decoder.sv
// Host command-word decoder: CSR writes, vector/matrix bursts, start and read requests.
// Optional SPI_CMD_DECODER_ERR_CNT_EN adds a saturating error counter mirrored at CSR 0xFFE.
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 10,
    parameter int unsigned       LEN_W    = 8,
    parameter logic [ADDR_W-1:0] VEC_BASE = 10'h000,
    parameter logic [ADDR_W-1:0] MAT_BASE = 10'h100,
    parameter int unsigned       TIMEOUT  = 1024
) (
    input logic              clk,
    input logic              rst_n,
    spi_cmd_decoder_if.slave bus
);
    localparam int unsigned CNT_W = 2 * LEN_W;
    localparam int unsigned TO_W  = $clog2(TIMEOUT) + 1;

    state_e            state_r, state_next_s;
    logic [TO_W-1:0]   to_cnt_r;
    logic [LEN_W-1:0]  vec_len_r, mat_cols_r;
    logic [11:0]       csr_addr_r;
    logic              csr_wr_en_r, start_r, rd_req_r, err_r;
    logic [11:0]       csr_wr_addr_r;
    logic [15:0]       csr_wr_data_r;
    op_e               op_s;
    logic [CNT_W-1:0]  vec_words_s, mat_words_s;
    logic              timeout_s, latch_addr_s, csr_we_s, start_s, rd_s;
    logic              err_set_s, err_clr_s, load_vec_s, load_mat_s, word_wr_s, last_s;
    logic              csr_en_nxt_s;
    logic [11:0]       csr_addr_nxt_s;
    logic [15:0]       csr_data_nxt_s;

    assign op_s        = word_opcode(bus.in_data);
    assign vec_words_s = CNT_W'(vec_len_r);
    assign mat_words_s = CNT_W'(vec_len_r) * CNT_W'(mat_cols_r);
    // The abort fires on the idle cycle that would bring the counter to TIMEOUT-1.
    assign timeout_s   = (state_r != ST_IDLE) && !bus.in_valid && (to_cnt_r == TO_W'(TIMEOUT - 2));

    assign bus.busy        = (state_r != ST_IDLE);
    assign bus.csr_wr_en   = csr_wr_en_r;
    assign bus.csr_wr_addr = csr_wr_addr_r;
    assign bus.csr_wr_data = csr_wr_data_r;
    assign bus.start       = start_r;
    assign bus.rd_req      = rd_req_r;
    assign bus.err         = err_r;

    // State register and inter-word idle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            to_cnt_r <= '0;
        end else begin
            state_r  <= state_next_s;
            to_cnt_r <= (state_next_s == ST_IDLE || bus.in_valid) ? '0 : to_cnt_r + TO_W'(1);
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        if (timeout_s) begin
            state_next_s = ST_IDLE;
        end else if (bus.in_valid) begin
            case (state_r)
                ST_IDLE: begin
                    case (op_s)
                        OP_CSR:  state_next_s = ST_CSR_DATA;
                        OP_VEC:  state_next_s = (vec_words_s != '0) ? ST_LOAD_VEC : ST_IDLE;
                        OP_MAT:  state_next_s = (mat_words_s != '0) ? ST_LOAD_MAT : ST_IDLE;
                        default: state_next_s = ST_IDLE;
                    endcase
                end
                ST_CSR_DATA:              state_next_s = ST_IDLE;
                ST_LOAD_VEC, ST_LOAD_MAT: state_next_s = last_s ? ST_IDLE : state_r;
                default:                  state_next_s = ST_IDLE;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Per-word action decode.
    always_comb begin
        latch_addr_s = 1'b0;
        csr_we_s     = 1'b0;
        start_s      = 1'b0;
        rd_s         = 1'b0;
        err_set_s    = timeout_s;
        err_clr_s    = 1'b0;
        load_vec_s   = 1'b0;
        load_mat_s   = 1'b0;
        word_wr_s    = 1'b0;
        if (bus.in_valid) begin
            case (state_r)
                ST_IDLE: begin
                    case (op_s)
                        OP_NOP:   latch_addr_s = 1'b0;
                        OP_CSR:   latch_addr_s = 1'b1;
                        OP_START: begin
                            start_s   = !bus.acc_busy;
                            err_set_s = bus.acc_busy;
                        end
                        OP_VEC:   load_vec_s = (vec_words_s != '0);
                        OP_MAT:   load_mat_s = (mat_words_s != '0);
                        OP_READ:  begin
                            rd_s      = !bus.acc_busy;
                            err_set_s = bus.acc_busy;
                        end
                        default:  err_set_s = 1'b1;
                    endcase
                end
                ST_CSR_DATA: begin
                    csr_we_s  = 1'b1;
                    err_clr_s = (csr_addr_r == CSR_ERR_CLR);
                end
                ST_LOAD_VEC, ST_LOAD_MAT: word_wr_s = 1'b1;
                default:                  word_wr_s = 1'b0;
            endcase
        end else begin
            word_wr_s = 1'b0;
        end
    end

`ifdef SPI_CMD_DECODER_ERR_CNT_EN
    logic [7:0] err_cnt_r;
    logic       err_mirror_r;

    assign bus.err_cnt = err_cnt_r;

    // Saturating error counter; a change schedules a mirror write one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r    <= 8'h00;
            err_mirror_r <= 1'b0;
        end else if (err_clr_s) begin
            err_cnt_r    <= 8'h00;
            err_mirror_r <= (err_cnt_r != 8'h00);
        end else if (err_set_s && err_cnt_r != ERR_CNT_MAX) begin
            err_cnt_r    <= err_cnt_r + 8'h01;
            err_mirror_r <= 1'b1;
        end else begin
            err_cnt_r    <= err_cnt_r;
            err_mirror_r <= 1'b0;
        end
    end
`endif

    // Next values of the CSR write port.
    always_comb begin
        csr_en_nxt_s   = 1'b0;
        csr_addr_nxt_s = csr_wr_addr_r;
        csr_data_nxt_s = csr_wr_data_r;
        if (csr_we_s) begin
            csr_en_nxt_s   = 1'b1;
            csr_addr_nxt_s = csr_addr_r;
            csr_data_nxt_s = bus.in_data;
        end
`ifdef SPI_CMD_DECODER_ERR_CNT_EN
        else if (err_mirror_r) begin
            csr_en_nxt_s   = 1'b1;
            csr_addr_nxt_s = CSR_ERR_CNT;
            csr_data_nxt_s = {8'h00, err_cnt_r};
        end
`endif
        else begin
            csr_en_nxt_s = 1'b0;
        end
    end

    // Latched CSR address and the burst-length registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_addr_r <= 12'h000;
            vec_len_r  <= '0;
            mat_cols_r <= '0;
        end else begin
            csr_addr_r <= latch_addr_s ? bus.in_data[11:0] : csr_addr_r;
            vec_len_r  <= (csr_we_s && csr_addr_r == CSR_VEC_LEN)  ? bus.in_data[LEN_W-1:0] : vec_len_r;
            mat_cols_r <= (csr_we_s && csr_addr_r == CSR_MAT_COLS) ? bus.in_data[LEN_W-1:0] : mat_cols_r;
        end
    end

    // Registered CSR port, pulses and sticky error (clear wins over set).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_wr_en_r   <= 1'b0;
            csr_wr_addr_r <= 12'h000;
            csr_wr_data_r <= 16'h0000;
            start_r       <= 1'b0;
            rd_req_r      <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            csr_wr_en_r   <= csr_en_nxt_s;
            csr_wr_addr_r <= csr_addr_nxt_s;
            csr_wr_data_r <= csr_data_nxt_s;
            start_r       <= start_s;
            rd_req_r      <= rd_s;
            if (err_clr_s) begin
                err_r <= 1'b0;
            end else if (err_set_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    cmd_burst_writer #(
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W),
        .VEC_BASE (VEC_BASE),
        .MAT_BASE (MAT_BASE)
    ) u_burst (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_vec    (load_vec_s),
        .load_mat    (load_mat_s),
        .vec_words   (vec_words_s),
        .mat_words   (mat_words_s),
        .word_wr     (word_wr_s),
        .word_data   (bus.in_data),
        .last        (last_s),
        .mem_wr_en   (bus.mem_wr_en),
        .mem_wr_addr (bus.mem_wr_addr),
        .mem_wr_data (bus.mem_wr_data)
    );
endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: a queue-based command model predicts every
// CSR/memory/start/read event; a negedge monitor pops and compares.
module tb_spi_cmd_decoder;
    localparam int          TIMEOUT  = 1024;
    localparam int unsigned VEC_BASE = 0;
    localparam int unsigned MAT_BASE = 256;

    typedef enum logic [1:0] {EV_CSR, EV_MEM, EV_START, EV_RD} ev_kind_e;
    typedef struct packed {
        ev_kind_e    kind;
        logic [11:0] addr;
        logic [15:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_cmd_decoder_if bus ();
    spi_cmd_decoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    ev_t         exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    bit          chk_en = 1'b0;
    int unsigned m_vec_len = 0;
    int unsigned m_mat_cols = 0;
    bit          m_err = 1'b0;
    bit          m_csr_pend = 1'b0;
    logic [11:0] m_csr_addr = 12'h000;
    logic [9:0]  m_burst_q[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    function automatic bit m_busy();
        return m_csr_pend || (m_burst_q.size() != 0);
    endfunction

    // Reference model: one accepted word at a time, events queued in output order.
    function automatic void model_word(input logic [15:0] w, input logic ab);
        logic [9:0] a;
        if (m_csr_pend) begin
            exp_q.push_back('{EV_CSR, m_csr_addr, w});
            if (m_csr_addr == 12'h001) m_vec_len = w[7:0];
            else if (m_csr_addr == 12'h002) m_mat_cols = w[7:0];
            else if (m_csr_addr == 12'hFFF) m_err = 1'b0;
            m_csr_pend = 1'b0;
        end else if (m_burst_q.size() != 0) begin
            a = m_burst_q.pop_front();
            exp_q.push_back('{EV_MEM, {2'b00, a}, w});
        end else begin
            case (w[15:12])
                4'h0: ;
                4'h1: begin m_csr_pend = 1'b1; m_csr_addr = w[11:0]; end
                4'h3: if (ab) m_err = 1'b1; else exp_q.push_back('{EV_START, 12'h000, 16'h0000});
                4'h4: for (int i = 0; i < int'(m_vec_len); i++) m_burst_q.push_back(10'(VEC_BASE + i));
                4'h5: for (int i = 0; i < int'(m_vec_len * m_mat_cols); i++) m_burst_q.push_back(10'(MAT_BASE + i));
                4'h6: if (ab) m_err = 1'b1; else exp_q.push_back('{EV_RD, 12'h000, 16'h0000});
                default: m_err = 1'b1;
            endcase
        end
    endfunction

    function automatic void got_event(input ev_kind_e k, input logic [11:0] a, input logic [15:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: got kind=%0d addr=0x%0h data=0x%0h, expected none at %0t", k, a, d, $time);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(k), 32'(e.kind));
            check("event_addr", 32'(a), 32'(e.addr));
            check("event_data", 32'(d), 32'(e.data));
        end
    endfunction

    // Monitor: compare every DUT strobe against the scoreboard, plus busy/err.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.csr_wr_en) got_event(EV_CSR, bus.csr_wr_addr, bus.csr_wr_data);
            if (bus.mem_wr_en) got_event(EV_MEM, {2'b00, bus.mem_wr_addr}, bus.mem_wr_data);
            if (bus.start)     got_event(EV_START, 12'h000, 16'h0000);
            if (bus.rd_req)    got_event(EV_RD, 12'h000, 16'h0000);
            if (chk_en) begin
                check("busy", 32'(bus.busy), 32'(m_busy()));
                check("err", 32'(bus.err), 32'(m_err));
            end
        end
    end

    // Entered and left at posedge+1; gap=0 gives back-to-back words.
    task automatic send_word(input logic [15:0] w, input logic ab, input int gap);
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        bus.acc_busy = ab;
        @(posedge clk);
        model_word(w, ab);
        #1;
        bus.in_valid = 1'b0;
        bus.acc_busy = 1'b0;
        bus.in_data  = 16'(($urandom & 32'h7) << 12);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_csr_wr_en"}, 32'(bus.csr_wr_en), 32'd0);
        check({tag, "_csr_wr_addr"}, 32'(bus.csr_wr_addr), 32'd0);
        check({tag, "_csr_wr_data"}, 32'(bus.csr_wr_data), 32'd0);
        check({tag, "_mem_wr_en"}, 32'(bus.mem_wr_en), 32'd0);
        check({tag, "_mem_wr_addr"}, 32'(bus.mem_wr_addr), 32'd0);
        check({tag, "_mem_wr_data"}, 32'(bus.mem_wr_data), 32'd0);
        check({tag, "_start"}, 32'(bus.start), 32'd0);
        check({tag, "_rd_req"}, 32'(bus.rd_req), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_err"}, 32'(bus.err), 32'd0);
    endtask

    task automatic drain_burst(input int max_gap);
        while (m_burst_q.size() != 0) send_word(16'($urandom), 1'b0, $urandom_range(0, max_gap));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] op;
        bus.in_data  = 16'h0000;
        bus.in_valid = 1'b0;
        bus.acc_busy = 1'b0;
        #23;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        chk_en = 1'b1;

        // Directed flow from the test plan.
        send_word(16'h1001, 1'b0, 0);
        send_word(16'h0003, 1'b0, 1);
        send_word(16'h1002, 1'b0, 0);
        send_word(16'h0002, 1'b0, 0);
        send_word(16'h4000, 1'b0, 2);
        send_word(16'h0012, 1'b0, 0);
        send_word(16'h0035, 1'b0, 1);
        send_word(16'h002A, 1'b0, 0);
        send_word(16'h5000, 1'b0, 1);
        send_word(16'h0031, 1'b0, 0);
        send_word(16'h0050, 1'b0, 0);
        send_word(16'h0001, 1'b0, 2);
        send_word(16'h0012, 1'b0, 0);
        send_word(16'h000A, 1'b0, 0);
        send_word(16'h0002, 1'b0, 0);
        send_word(16'h3000, 1'b0, 0);
        send_word(16'h6000, 1'b1, 1);
        send_word(16'h6000, 1'b0, 1);
        send_word(16'h3000, 1'b1, 1);
        send_word(16'h1FFF, 1'b0, 1);
        send_word(16'h0000, 1'b0, 0);
        send_word(16'h2000, 1'b0, 1);
        send_word(16'h1FFF, 1'b0, 0);
        send_word(16'h0000, 1'b0, 0);

        // Vector-burst timeout: exactly one write, then abort.
        send_word(16'h4000, 1'b0, 1);
        send_word(16'h00AB, 1'b0, 0);
        chk_en = 1'b0;
        idle(TIMEOUT / 2);
        @(negedge clk);
        check("timeout_vec_still_busy", 32'(bus.busy), 32'd1);
        idle(TIMEOUT);
        @(negedge clk);
        check("timeout_vec_busy", 32'(bus.busy), 32'd0);
        check("timeout_vec_err", 32'(bus.err), 32'd1);
        m_burst_q.delete();
        m_err = 1'b1;
        idle(1);
        chk_en = 1'b1;

        // CSR-data timeout: no partial CSR write.
        send_word(16'h1001, 1'b0, 0);
        chk_en = 1'b0;
        idle(TIMEOUT + 2);
        @(negedge clk);
        check("timeout_csr_busy", 32'(bus.busy), 32'd0);
        check("timeout_csr_err", 32'(bus.err), 32'd1);
        m_csr_pend = 1'b0;
        idle(1);
        chk_en = 1'b1;
        send_word(16'h4000, 1'b0, 0);
        drain_burst(1);

        // Matrix burst crossing the top of the address space.
        send_word(16'h1001, 1'b0, 0);
        send_word(16'h00FF, 1'b0, 0);
        send_word(16'h1002, 1'b0, 0);
        send_word(16'h0004, 1'b0, 0);
        send_word(16'h5000, 1'b0, 0);
        drain_burst(0);
        send_word(16'h1002, 1'b0, 0);
        send_word(16'h0000, 1'b0, 0);
        send_word(16'h5000, 1'b0, 0);
        send_word(16'h3000, 1'b0, 0);

        // Randomized command mix.
        for (int n = 0; n < 300; n++) begin
            int g;
            g = $urandom_range(0, 2);
            case ($urandom_range(0, 9))
                0: send_word({4'h0, 12'($urandom)}, 1'b0, g);
                1: begin send_word(16'h1001, 1'b0, g); send_word(16'($urandom_range(0, 6)), 1'b0, g); end
                2: begin send_word(16'h1002, 1'b0, g); send_word(16'($urandom_range(0, 5)), 1'b0, g); end
                3: begin
                    send_word({4'h1, 12'($urandom_range(3, 12'hFFD))}, 1'b0, g);
                    send_word(16'($urandom), 1'b0, g);
                end
                4: send_word({4'h3, 12'($urandom)}, 1'($urandom), g);
                5: send_word({4'h6, 12'($urandom)}, 1'($urandom), g);
                6: begin send_word({4'h4, 12'($urandom)}, 1'b0, g); drain_burst(2); end
                7: begin send_word({4'h5, 12'($urandom)}, 1'b0, g); drain_burst(2); end
                8: begin
                    op = ($urandom_range(0, 9) == 0) ? 4'h2 : 4'($urandom_range(7, 15));
                    send_word({op, 12'($urandom)}, 1'b0, g);
                end
                default: begin send_word(16'h1FFF, 1'b0, g); send_word(16'($urandom), 1'b0, g); end
            endcase
        end

        // Reset in the middle of a matrix burst, with err set and a CSR address held.
        send_word(16'h2000, 1'b0, 0);
        send_word(16'h1001, 1'b0, 0);
        send_word(16'h0002, 1'b0, 0);
        send_word(16'h1002, 1'b0, 0);
        send_word(16'h0003, 1'b0, 0);
        send_word(16'h5000, 1'b0, 0);
        send_word(16'h1234, 1'b0, 0);
        send_word(16'h5678, 1'b0, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midburst_reset");
        exp_q.delete();
        m_burst_q.delete();
        m_vec_len = 0;
        m_mat_cols = 0;
        m_err = 1'b0;
        m_csr_pend = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        send_word(16'h4000, 1'b0, 0);
        send_word(16'h3000, 1'b0, 1);

        idle(4);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
